// File: rtl/countdown_sched_pkg.sv
// rtl/countdown_sched_pkg.sv - shared types and defaults for the countdown scheduler
package countdown_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;

  // Next round-robin pointer: the requester after the one just served.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/countdown_scheduler_if.sv
// rtl/countdown_scheduler_if.sv - client-side bundle of the countdown scheduler
interface countdown_scheduler_if
  import countdown_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] dur;
  logic                  pause;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;

  modport master (
    output req, dur, pause,
    input  grant, busy, count, done
  );

  modport slave (
    input  req, dur, pause,
    output grant, busy, count, done
  );

endinterface

// File: rtl/countdown_core.sv
// rtl/countdown_core.sv - loadable down-counter that saturates at zero
module countdown_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec && (q != '0)) begin
      q <= q - WIDTH'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/countdown_scheduler.sv
// rtl/countdown_scheduler.sv - round-robin owner of one shared countdown timer
module countdown_scheduler
  import countdown_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  countdown_scheduler_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;

  logic             any_req;
  logic             owner_req;
  logic             core_load;
  logic             core_dec;
  logic             core_zero;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] win_dur;

  // Search upward from ptr with wrap: rotate, first-set, rotate back in one pass.
  always_comb begin
    int   idx;
    logic found;
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign any_req   = |bus.req;
  assign owner_req = bus.req[owner];
  assign win_dur   = bus.dur[int'(win)*WIDTH +: WIDTH];

  assign core_load = (state == IDLE) && any_req;
  assign core_dec  = (state == COUNT) && owner_req && !bus.pause && !core_zero;

  countdown_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .load_val (win_dur),
    .dec      (core_dec),
    .q        (core_q),
    .zero     (core_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= COUNT;
            owner   <= win;
            grant_q <= NREQ'(1) << win;
            busy_q  <= 1'b1;
          end
        end
        COUNT: begin
          // Abort outranks pause; pause outranks both decrement and completion.
          if (!owner_req) begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr     <= PW'(wrap_inc(int'(owner), NREQ));
          end else if (!bus.pause && core_zero) begin
            state  <= DONE;
            done_q <= grant_q;
          end
        end
        DONE: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr     <= PW'(wrap_inc(int'(owner), NREQ));
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = core_q;

endmodule

// File: tb/tb_countdown_scheduler.sv
// tb/tb_countdown_scheduler.sv - self-checking bench for countdown_scheduler
module tb_countdown_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;

  countdown_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  countdown_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] dur;
    logic        pause;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  count;
    logic [3:0]  done;
  } vec_t;

  vec_t tbl[$];

  // Reference: who owns the timer, how much is left, and whether the slot has finished.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_fin   = 1'b0;

  task automatic model_step();
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_fin = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (bus.req[i]) begin
          m_owner = i;
          m_cnt   = int'(bus.dur[i*WIDTH +: WIDTH]);
          break;
        end
      end
    end else if (m_fin) begin
      m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_fin = 1'b0;
    end else if (!bus.req[m_owner]) begin
      m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
    end else if (bus.pause) begin
      m_cnt = m_cnt;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
    end else begin
      m_fin = 1'b1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] eg, ed;
    logic [10:0] act, exp;
    eg  = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    ed  = m_fin ? eg : '0;
    act = {bus.grant, bus.busy, bus.count, bus.done};
    exp = {eg, (m_owner >= 0), 4'(m_cnt), ed};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model: got grant=%b busy=%b count=%0d done=%b expected grant=%b busy=%b count=%0d done=%b at %0t",
               bus.grant, bus.busy, bus.count, bus.done, eg, (m_owner >= 0), m_cnt, ed, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.req = '0; bus.pause = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_count(input int v, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (bus.busy && bus.count == 4'(v)) begin ok = 1'b1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  // Runs one slot from idle and returns the number of edges from grant to visible done.
  task automatic timed_slot(input int pat, input int plen, output int lat);
    bit armed;
    int left;
    armed = 1'b0; left = 0; lat = -1;
    for (int c = 1; c <= 60; c++) begin
      cycle();
      if (bus.done != 0) begin lat = c; break; end
      if (!armed && bus.busy && int'(bus.count) == pat) begin armed = 1'b1; left = plen; end
      if (left > 0) begin bus.pause = 1'b1; left--; end
      else bus.pause = 1'b0;
    end
    bus.pause = 1'b0;
    bus.req   = '0;
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [15:0] d,
                              input logic p, input logic [3:0] g, input logic b,
                              input logic [3:0] c, input logic [3:0] dn);
    vec_t v;
    v.rst_n = r; v.req = q; v.dur = d; v.pause = p;
    v.grant = g; v.busy = b; v.count = c; v.done = dn;
    return v;
  endfunction

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_seq [$];

  initial begin
    int lat;
    int last;
    rst_n = 1'b0; bus.req = '0; bus.dur = '0; bus.pause = 1'b0;

    // Single slot of 5 (dur changes after grant are ignored), then zero duration with priority.
    tbl.push_back(mk(0, 4'b0000, 16'h0005, 0, 4'b0000, 0, 4'd0, 4'b0000));
    tbl.push_back(mk(1, 4'b0001, 16'h0005, 0, 4'b0001, 1, 4'd5, 4'b0000));
    tbl.push_back(mk(1, 4'b0001, 16'h0009, 0, 4'b0001, 1, 4'd4, 4'b0000));
    tbl.push_back(mk(1, 4'b0001, 16'h0009, 0, 4'b0001, 1, 4'd3, 4'b0000));
    tbl.push_back(mk(1, 4'b0001, 16'h0009, 0, 4'b0001, 1, 4'd2, 4'b0000));
    tbl.push_back(mk(1, 4'b0001, 16'h0009, 0, 4'b0001, 1, 4'd1, 4'b0000));
    tbl.push_back(mk(1, 4'b0001, 16'h0009, 0, 4'b0001, 1, 4'd0, 4'b0000));
    tbl.push_back(mk(1, 4'b0001, 16'h0009, 0, 4'b0001, 1, 4'd0, 4'b0001));
    tbl.push_back(mk(1, 4'b0000, 16'h0009, 0, 4'b0000, 0, 4'd0, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 16'h0009, 0, 4'b0000, 0, 4'd0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h2000, 0, 4'b0000, 0, 4'd0, 4'b0000));
    tbl.push_back(mk(1, 4'b1001, 16'h2000, 0, 4'b0001, 1, 4'd0, 4'b0000));
    tbl.push_back(mk(1, 4'b1001, 16'h2000, 0, 4'b0001, 1, 4'd0, 4'b0001));
    tbl.push_back(mk(1, 4'b1000, 16'h2000, 0, 4'b0000, 0, 4'd0, 4'b0000));
    tbl.push_back(mk(1, 4'b1000, 16'h2000, 0, 4'b1000, 1, 4'd2, 4'b0000));
    tbl.push_back(mk(1, 4'b1000, 16'h2000, 0, 4'b1000, 1, 4'd1, 4'b0000));
    tbl.push_back(mk(1, 4'b1000, 16'h2000, 0, 4'b1000, 1, 4'd0, 4'b0000));
    tbl.push_back(mk(1, 4'b1000, 16'h2000, 0, 4'b1000, 1, 4'd0, 4'b1000));
    tbl.push_back(mk(1, 4'b0000, 16'h2000, 0, 4'b0000, 0, 4'd0, 4'b0000));

    for (int r = 0; r < tbl.size(); r++) begin
      rst_n = tbl[r].rst_n; bus.req = tbl[r].req; bus.dur = tbl[r].dur; bus.pause = tbl[r].pause;
      cycle();
      n_tests++;
      if ({bus.grant, bus.busy, bus.count, bus.done} !== {tbl[r].grant, tbl[r].busy, tbl[r].count, tbl[r].done}) begin
        n_fail++;
        $display("FAIL vec%0d: got grant=%b busy=%b count=%0d done=%b expected grant=%b busy=%b count=%0d done=%b",
                 r, bus.grant, bus.busy, bus.count, bus.done, tbl[r].grant, tbl[r].busy, tbl[r].count, tbl[r].done);
      end
    end

    // Round-robin with all requesters held and dur=1.
    do_reset();
    bus.req = 4'b1111; bus.dur = 16'h1111;
    last = -1;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (bus.done != 0) begin
        chk("rr_done_is_grant", int'(bus.done), int'(bus.grant));
        if (last >= 0) chk("rr_period", c - last, 4);
        last = c;
        rr_seq.push_back(bus.done);
        if (rr_seq.size() == 5) break;
      end
    end
    chk("rr_slot_count", rr_seq.size(), 5);
    for (int i = 0; i < rr_seq.size(); i++) chk($sformatf("rr_order%0d", i), int'(rr_seq[i]), int'(rr_exp[i]));
    cycle();
    chk("rr_idle_gap", int'(bus.busy), 0);

    // Pause: none, 3 cycles at count=2, 4 cycles at count=0.
    do_reset();
    bus.dur = 16'h0040;
    bus.req = 4'b0010; timed_slot(-1, 0, lat); chk("lat_nopause", lat, 6);
    cycle();
    bus.req = 4'b0010; timed_slot(2, 3, lat);  chk("lat_pause_mid", lat, 9);
    cycle();
    bus.req = 4'b0010; timed_slot(0, 4, lat);  chk("lat_pause_zero", lat, 10);
    cycle();

    // Abort at count=3; the next search starts from requester 3.
    do_reset();
    bus.req = 4'b0100; bus.dur = 16'h0600;
    wait_count(3, "abort_reach3");
    bus.req = 4'b0000;
    cycle();
    chk("abort_grant", int'(bus.grant), 0);
    chk("abort_busy", int'(bus.busy), 0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("abort_no_done", int'(bus.done), 0);
    end
    bus.req = 4'b1111;
    cycle();
    chk("abort_next_grant", int'(bus.grant), 4'b1000);

    // Reset while counting returns the pointer to requester 0.
    do_reset();
    bus.req = 4'b0001; bus.dur = 16'h0005;
    wait_count(2, "rst_reach2");
    rst_n = 1'b0;
    cycle();
    chk("rst_outputs", int'({bus.grant, bus.busy, bus.count, bus.done}), 0);
    rst_n = 1'b1; bus.req = 4'b1111;
    cycle();
    chk("rst_ptr_grant", int'(bus.grant), 4'b0001);

    // Random traffic against the reference.
    do_reset();
    bus.req = '0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(99) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i]) begin
          if ($urandom_range(31) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          bus.req[i] = 1'b1;
        end
      end
      if ($urandom_range(4) == 0) bus.dur = 16'($urandom);
      bus.pause = ($urandom_range(3) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_scheduler.md
# countdown_scheduler

Shares one 4-bit countdown timer between several requesters. Each requester asks for a timed slot of a given duration, and a round-robin arbiter picks a winner. The block loads the winner's duration into the timer, counts down to zero, then returns a one-cycle completion pulse to that requester. It sits between client logic and the countdown datapath and owns every load and decrement of the timer.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, duration/counter width in bits

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- req  in  NREQ  per-requester slot request, level, held until done
- dur  in  NREQ*WIDTH  per-requester duration, slice i = dur[i*WIDTH +: WIDTH]
- pause  in  1  freeze the running countdown
- grant  out  NREQ  one-hot owner of the timer, 0 when idle
- busy  out  1  high whenever the state is not IDLE
- count  out  WIDTH  current timer value
- done  out  NREQ  one-hot, one-cycle completion pulse to the owner

## Operation
- States: IDLE, COUNT, DONE.
- Reset (rst_n low at an edge): state IDLE; grant, done, count and busy all 0; round-robin pointer 0, so requester 0 has top priority.
- **IDLE:** if any req bit is set, choose the first set bit searching upward from the pointer, with wrap-around.
  - Next cycle: state COUNT, grant = winner, count = dur[winner].
  - Winner's dur is sampled only on this edge; later changes are ignored.
  - If no req bit is set, hold IDLE with count unchanged.
- **COUNT** (rules in priority order):
  - Owner's req low: abort. Next state IDLE, grant cleared, no done pulse, pointer = winner+1.
  - Otherwise pause high: hold everything. Count does not change and completion is suppressed.
  - Otherwise count != 0: count decrements by 1.
  - Otherwise count == 0: next state DONE, done = grant.
- **DONE:** lasts exactly one cycle and ignores pause.
  - Next state IDLE; grant and done cleared; pointer = winner+1 mod NREQ; count stays at 0.
- Requests from non-owners are ignored until the block is back in IDLE.
- A request that is already high re-arbitrates on the first IDLE cycle.
- Duration 0 is legal: count loads 0 and the block goes to DONE on the first unpaused COUNT edge.
- count never underflows, and decrement is unsigned modulo-free.

## Timing
- Let E0 be the edge on which IDLE grants. Without pause, done is high in the cycle after edge E0+dur+1, which is dur+2 cycles after req is seen.
- Each paused cycle in COUNT adds exactly 1 cycle of latency.
- Back-to-back slots:
  - There is at least one IDLE cycle between a done pulse and the next grant.
  - The minimum period is dur+3 cycles.
- busy rises the cycle after E0 and falls the cycle after DONE.
- grant is stable from E0 through the DONE cycle inclusive.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- rst_n low during COUNT or DONE: next cycle fully reset, and no done pulse is emitted.

## Structure
- Package countdown_sched_pkg:
  - state_t enum (IDLE, COUNT, DONE)
  - default NREQ/WIDTH localparams
- Sub-module countdown_core, instantiated once:
  - Ports: clk, rst_n, load, load_val[WIDTH], dec, q[WIDTH], zero.
  - Synchronous active-low reset to 0.
  - load takes priority over dec.
- Arbitration (rotate, priority-encode, rotate back) and the FSM live in the top level.

## Test plan
- **Single slot:** reset, req=0001, dur0=5, pause=0 -> grant=0001 after E0; count steps 5,4,3,2,1,0; done=0001 for exactly 1 cycle dur+2 cycles after req; busy low afterwards.
- **Round-robin:** req=1111 held, all dur=1 -> grants in order 0001, 0010, 0100, 1000, 0001; each done one-hot matches its grant; one idle cycle between slots.
- **Pause:** req=0010, dur1=4, pause high for 3 cycles while count=2 -> count holds at 2; done arrives 3 cycles later than the unpaused case; pause held at count=0 delays done until pause drops.
- **Abort:** req=0100, dur2=6, drop req2 when count=3 -> state IDLE next cycle; grant=0; done never pulses; next grant starts searching at requester 3.
- **Zero duration and priority:** req=1001, dur0=0 -> requester 0 granted and done pulses 2 cycles after req; requester 3 then granted.
- **Reset mid-operation:** rst_n low for one edge while count=2 -> next cycle grant=0, count=0, busy=0, done=0; pointer back to 0, so req=1111 then grants 0001.
